alu_nibble_sequencer: RTL and testbench
=======================================

Name: alu_nibble_sequencer

Overview:
- Multi-pass operand sequencer wrapped around the existing 4-bit ALU.
- Accepts NIBBLES*4-bit commands over a valid/ready handshake.
- Drives the 4-bit ALU one nibble per cycle, LSB nibble first, chaining carry between passes.
- Assembles the full-width result, then presents it downstream on a second valid/ready handshake.

Parameters:
NIBBLES, 2, number of 4-bit passes per command; operand width W = 4*NIBBLES (legal values 1 to 8)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid  input  1  command valid
in_ready  output  1  sequencer can accept a command
in_a  input  W  operand A
in_b  input  W  operand B
in_op  input  3  command: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; all others illegal
in_cin  input  1  carry-in, used by ADD only
alu_a  output  4  nibble of A to the ALU
alu_b  output  4  nibble of B to the ALU
alu_op  output  3  ALU operation code
alu_cin  output  1  ALU carry-in
alu_result  input  4  ALU result, combinational from alu_*
alu_cout  input  1  ALU carry-out, combinational
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_result  output  W  full-width result
out_cout  output  1  final carry-out (ADD/SUB), else 0
out_ovf  output  1  signed overflow (ADD/SUB), else 0
out_err  output  1  illegal op flag

Behaviour:
- Reset (rst_n=0, asynchronous) forces:
  - state IDLE, nibble counter 0
  - in_ready=1, out_valid=0
  - out_result=0, out_cout=0, out_ovf=0, out_err=0
  - alu_a=0, alu_b=0, alu_op=000, alu_cin=0
- Reset mid-command aborts the command; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_a, in_b, in_op, in_cin; clear result register.
  - Legal op: go to RUN, counter=0.
  - Illegal op: go to DONE with out_err=1, out_result=0.
- RUN:
  - in_ready=0.
  - alu_a/alu_b = nibble[counter] of latched operands.
  - alu_op mapping: AND->000, OR->001, ADD->010, SUB->110, SLT->110 (SLT is computed as a subtraction).
  - alu_cin on counter 0: in_cin for ADD, 1 for SUB/SLT, 0 for AND/OR.
  - alu_cin on later passes: registered alu_cout from the previous pass.
  - Each edge: write alu_result into nibble[counter] of the result register; register alu_cout; increment counter.
  - After pass NIBBLES-1, go to DONE and compute the flags:
    - ADD/SUB: out_cout = last alu_cout.
    - ADD/SUB: out_ovf = sign bits of the effective operands (B inverted for SUB) equal, and result sign differs from them.
    - SLT: out_result = {W-1 zeros, diff_msb XOR ovf}; out_cout=0; out_ovf=0.
    - AND/OR: out_cout=0; out_ovf=0.
- Outside RUN, the alu_* outputs are held at reset values.
- DONE:
  - out_valid=1; all out_* held stable until out_ready.
  - On out_valid&out_ready go to IDLE; out_valid drops the following cycle.
  - in_ready=0, so there is no overlap between commands.
- Latency:
  - Acceptance edge E0; out_valid high after edge E0+NIBBLES.
  - Illegal op: out_valid high after E0.
  - Minimum spacing between accepted commands is NIBBLES+2 cycles.
- Arithmetic is modulo 2^W.
- Carry between passes comes only from alu_cout; the block performs no internal addition.
- out_ready asserted while not in DONE is ignored.
- in_valid is ignored outside IDLE; the upstream stage must hold the command until in_ready.

Test Plan:
- ADD, NIBBLES=2: a=0x3C, b=0x59, cin=0 -> out_result=0x95, out_cout=0, out_ovf=1, out_err=0. out_valid rises 2 edges after accept. Pass 0 shows alu_a=C, alu_b=9, alu_op=010, alu_cin=0; pass 1 shows alu_cin=1.
- SUB: a=0x10, b=0x01 -> out_result=0x0F, out_cout=1, out_ovf=0. Pass 0 shows alu_op=110, alu_cin=1.
- SLT: a=0x80, b=0x01 -> out_result=0x01. With a=0x01, b=0x80 -> out_result=0x00. AND 0xF0/0x3C -> 0x30; OR -> 0xFC.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required:
  - out_* stay stable throughout.
  - in_ready stays 0; a command presented meanwhile is not accepted.
  - That command is accepted in the first IDLE cycle.
- Illegal op 011: out_valid high after 1 edge, out_err=1, out_result=0x00, alu_* never leave reset values.
- Reset mid-RUN: drop rst_n after pass 0. Immediately: out_valid=0, in_ready=1, alu_*=0. After release, a fresh ADD 0x01+0x01 returns 0x02.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer
// Runs a W-bit command (W = 4*NIBBLES) through an external combinational 4-bit
// ALU, one nibble per cycle with the LSB nibble first. The carry is chained
// between passes using the registered ALU carry-out. The full-width result is
// then presented on a downstream valid/ready handshake.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          command handshake (accepted only in IDLE)
//   in_a, in_b [W]             operands
//   in_op [3]                  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   in_cin                     carry-in (ADD only)
//   alu_a, alu_b, alu_op,      drive to the 4-bit ALU; held at zero outside RUN
//   alu_cin
//   alu_result, alu_cout       combinational ALU response
//   out_valid/out_ready        result handshake (held stable in DONE)
//   out_result [W], out_cout,  result, final carry, signed overflow,
//   out_ovf, out_err           illegal-op flag
module alu_nibble_sequencer #(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] in_a,
  input  logic [4*NIBBLES-1:0] in_b,
  input  logic [2:0]           in_op,
  input  logic                 in_cin,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_cin,
  input  logic [3:0]           alu_result,
  input  logic                 alu_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_result,
  output logic                 out_cout,
  output logic                 out_ovf,
  output logic                 out_err
);

  localparam int W = 4 * NIBBLES;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [3:0]     cnt, cnt_n;
  logic [W-1:0]   a_r, a_n;
  logic [W-1:0]   b_r, b_n;
  logic [2:0]     op_r, op_n;
  logic           cin_r, cin_n;
  logic [W-1:0]   res_r, res_n;
  logic           carry_r, carry_n;
  logic           cout_r, cout_n;
  logic           ovf_r, ovf_n;
  logic           err_r, err_n;

  logic [5:0]     bit_pos;
  logic [W-1:0]   res_merged;
  logic           sign_a, sign_b_eff, ovf_calc;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
  endfunction

  // Registered state, operands and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= 3'b000;
      cin_r   <= 1'b0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      a_r     <= a_n;
      b_r     <= b_n;
      op_r    <= op_n;
      cin_r   <= cin_n;
      res_r   <= res_n;
      carry_r <= carry_n;
      cout_r  <= cout_n;
      ovf_r   <= ovf_n;
      err_r   <= err_n;
    end
  end

  // Next-state logic and the ALU drive for the current pass.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    a_n        = a_r;
    b_n        = b_r;
    op_n       = op_r;
    cin_n      = cin_r;
    res_n      = res_r;
    carry_n    = carry_r;
    cout_n     = cout_r;
    ovf_n      = ovf_r;
    err_n      = err_r;
    alu_a      = 4'd0;
    alu_b      = 4'd0;
    alu_op     = 3'b000;
    alu_cin    = 1'b0;

    bit_pos    = {cnt, 2'b00};
    // Replace the current nibble of the result with the ALU output.
    res_merged = (res_r & ~(W'(4'hF) << bit_pos)) | (W'(alu_result) << bit_pos);
    // SUB and SLT (op[2]=1) subtract, so B's effective sign is inverted.
    sign_a     = a_r[W-1];
    sign_b_eff = b_r[W-1] ^ op_r[2];
    ovf_calc   = (sign_a == sign_b_eff) && (alu_result[3] != sign_a);

    case (state)
      IDLE: begin
        if (in_valid) begin
          a_n     = in_a;
          b_n     = in_b;
          op_n    = in_op;
          cin_n   = in_cin;
          res_n   = '0;
          carry_n = 1'b0;
          cout_n  = 1'b0;
          ovf_n   = 1'b0;
          cnt_n   = 4'd0;
          if (op_legal(in_op)) begin
            err_n   = 1'b0;
            state_n = RUN;
          end else begin
            err_n   = 1'b1;
            state_n = DONE;
          end
        end else begin
          state_n = IDLE;
        end
      end

      RUN: begin
        alu_a  = 4'(a_r >> bit_pos);
        alu_b  = 4'(b_r >> bit_pos);
        // SLT is evaluated as a subtraction on the ALU.
        alu_op = (op_r == OP_SLT) ? OP_SUB : op_r;
        if (cnt == 4'd0) begin
          case (op_r)
            OP_ADD:         alu_cin = cin_r;
            OP_SUB, OP_SLT: alu_cin = 1'b1;
            default:        alu_cin = 1'b0;
          endcase
        end else begin
          alu_cin = carry_r;
        end

        res_n   = res_merged;
        carry_n = alu_cout;
        cnt_n   = cnt + 4'd1;

        if (cnt == 4'(NIBBLES - 1)) begin
          state_n = DONE;
          case (op_r)
            OP_ADD, OP_SUB: begin
              cout_n = alu_cout;
              ovf_n  = ovf_calc;
            end
            OP_SLT: begin
              // Signed less-than: difference sign corrected by overflow.
              res_n  = W'(alu_result[3] ^ ovf_calc);
              cout_n = 1'b0;
              ovf_n  = 1'b0;
            end
            default: begin
              cout_n = 1'b0;
              ovf_n  = 1'b0;
            end
          endcase
        end else begin
          state_n = RUN;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign out_result = res_r;
  assign out_cout   = cout_r;
  assign out_ovf    = ovf_r;
  assign out_err    = err_r;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer (NIBBLES=2) with a behavioural
// 4-bit ALU attached to the alu_* port group.
module tb_alu_nibble_sequencer;

  localparam int NIB = 2;
  localparam int W   = 4 * NIB;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_op;
  logic         in_cin;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [2:0]   alu_op;
  logic         alu_cin;
  logic [3:0]   alu_result;
  logic         alu_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_cout;
  logic         out_ovf;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_cout(out_cout), .out_ovf(out_ovf),
    .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit ALU.
  always_comb begin
    case (alu_op)
      3'b000:  {alu_cout, alu_result} = {1'b0, alu_a & alu_b};
      3'b001:  {alu_cout, alu_result} = {1'b0, alu_a | alu_b};
      3'b010:  {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
      3'b110:  {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
      default: {alu_cout, alu_result} = 5'd0;
    endcase
  end

  // Present a command on a falling edge and wait for out_valid; lat counts
  // rising edges from acceptance until out_valid is seen.
  task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op, input logic cin, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_cin = cin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL cmd_timeout: out_valid=%0b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = 3'b000; in_cin = 1'b0;
    #12;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_hs: in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
    checks++;
    if ({out_result, out_cout, out_ovf, out_err} !== {W'(0), 3'b000}) begin
      errors++; $display("FAIL reset_out: got %h/%b%b%b required 00/000", out_result, out_cout, out_ovf, out_err);
    end
    checks++;
    if ({alu_a, alu_b, alu_op, alu_cin} !== 12'd0) begin
      errors++; $display("FAIL reset_alu: got %h %h %b %b required zeros", alu_a, alu_b, alu_op, alu_cin);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat;
    @(negedge clk);
    in_a = 8'h3C; in_b = 8'h59; in_op = 3'b010; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({alu_a, alu_b, alu_op, alu_cin} !== {4'hC, 4'h9, 3'b010, 1'b0}) begin
      errors++; $display("FAIL add_pass0: got %h %h %b %b required c 9 010 0", alu_a, alu_b, alu_op, alu_cin);
    end
    @(negedge clk);
    checks++;
    if ({alu_a, alu_b, alu_cin, out_valid} !== {4'h3, 4'h5, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_pass1: got %h %h cin=%b valid=%b required 3 5 1 0", alu_a, alu_b, alu_cin, out_valid);
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL add_latency: got %0d required 2", lat);
    end
    checks++;
    if ({out_result, out_cout, out_ovf, out_err} !== {8'h95, 3'b010}) begin
      errors++; $display("FAIL add_result: got %h c=%b v=%b e=%b required 95 0 1 0", out_result, out_cout, out_ovf, out_err);
    end
    checks++;
    if ({alu_a, alu_b, alu_op, alu_cin} !== 12'd0) begin
      errors++; $display("FAIL add_alu_idle: got %h %h %b %b required zeros", alu_a, alu_b, alu_op, alu_cin);
    end
    drain();
  endtask

  task automatic test_sub();
    int lat;
    @(negedge clk);
    in_a = 8'h10; in_b = 8'h01; in_op = 3'b110; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({alu_op, alu_cin} !== {3'b110, 1'b1}) begin
      errors++; $display("FAIL sub_pass0: got op=%b cin=%b required 110 1", alu_op, alu_cin);
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({out_result, out_cout, out_ovf, out_err} !== {8'h0F, 3'b100}) begin
      errors++; $display("FAIL sub_result: got %h c=%b v=%b e=%b required 0f 1 0 0", out_result, out_cout, out_ovf, out_err);
    end
    drain();
  endtask

  task automatic test_slt_logic();
    int lat;
    run_cmd(8'h80, 8'h01, 3'b111, 1'b0, lat);
    checks++;
    if ({out_result, out_cout, out_ovf} !== {8'h01, 2'b00}) begin
      errors++; $display("FAIL slt_lt: got %h c=%b v=%b required 01 0 0", out_result, out_cout, out_ovf);
    end
    drain();
    run_cmd(8'h01, 8'h80, 3'b111, 1'b0, lat);
    checks++;
    if ({out_result, out_cout, out_ovf} !== {8'h00, 2'b00}) begin
      errors++; $display("FAIL slt_ge: got %h c=%b v=%b required 00 0 0", out_result, out_cout, out_ovf);
    end
    drain();
    run_cmd(8'hF0, 8'h3C, 3'b000, 1'b1, lat);
    checks++;
    if ({out_result, out_cout, out_ovf} !== {8'h30, 2'b00}) begin
      errors++; $display("FAIL and: got %h c=%b v=%b required 30 0 0", out_result, out_cout, out_ovf);
    end
    drain();
    run_cmd(8'hF0, 8'h3C, 3'b001, 1'b0, lat);
    checks++;
    if ({out_result, out_cout, out_ovf} !== {8'hFC, 2'b00}) begin
      errors++; $display("FAIL or: got %h c=%b v=%b required fc 0 0", out_result, out_cout, out_ovf);
    end
    drain();
    // ADD with carry-in and a carry out of the top nibble: 0xFF+0x00+1.
    run_cmd(8'hFF, 8'h00, 3'b010, 1'b1, lat);
    checks++;
    if ({out_result, out_cout, out_ovf} !== {8'h00, 2'b10}) begin
      errors++; $display("FAIL add_cin: got %h c=%b v=%b required 00 1 0", out_result, out_cout, out_ovf);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W+2:0] snap;
    run_cmd(8'h3C, 8'h59, 3'b010, 1'b0, lat);
    snap = {out_result, out_cout, out_ovf, out_err};
    in_a = 8'h01; in_b = 8'h02; in_op = 3'b010; in_cin = 1'b0; in_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_result, out_cout, out_ovf, out_err} !== {2'b10, snap}) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b r=%b %h required v=1 r=0 %h", i, out_valid, in_ready, {out_result, out_cout, out_ovf, out_err}, snap);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_idle: in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({in_ready, alu_a, alu_b} !== {1'b0, 4'h1, 4'h2}) begin
      errors++; $display("FAIL bp_accept: in_ready=%b alu=%h%h required 0 12", in_ready, alu_a, alu_b);
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (out_result !== 8'h03) begin
      errors++; $display("FAIL bp_second: got %h required 03", out_result);
    end
    drain();
  endtask

  task automatic test_illegal();
    int lat;
    @(negedge clk);
    in_a = 8'hAB; in_b = 8'hCD; in_op = 3'b011; in_cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_err, out_result, out_cout, out_ovf} !== {2'b11, 8'h00, 2'b00}) begin
      errors++; $display("FAIL illegal: got v=%b e=%b %h c=%b o=%b required 1 1 00 0 0", out_valid, out_err, out_result, out_cout, out_ovf);
    end
    checks++;
    if ({alu_a, alu_b, alu_op, alu_cin} !== 12'd0) begin
      errors++; $display("FAIL illegal_alu: got %h %h %b %b required zeros", alu_a, alu_b, alu_op, alu_cin);
    end
    drain();
    lat = 0;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    in_a = 8'h3C; in_b = 8'h59; in_op = 3'b010; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, alu_a, alu_b, alu_op, alu_cin, out_result} !== {2'b01, 12'd0, 8'h00}) begin
      errors++; $display("FAIL rst_mid: got v=%b r=%b alu=%h%h%b%b res=%h required 0 1 zeros 00", out_valid, in_ready, alu_a, alu_b, alu_op, alu_cin, out_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(8'h01, 8'h01, 3'b010, 1'b0, lat);
    checks++;
    if ({out_result, out_cout, out_ovf, out_err} !== {8'h02, 3'b000}) begin
      errors++; $display("FAIL rst_fresh: got %h c=%b v=%b e=%b required 02 0 0 0", out_result, out_cout, out_ovf, out_err);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_slt_logic();
    test_backpressure();
    test_illegal();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
